data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_if.sv | 33 +++
 rtl/data_memory_responder.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// -----------------------------------------------------------------------------
// data_memory_responder_if
// Purpose : Groups the datapath <-> data-memory request/response signals.
// Signals : MOV      request valid from the datapath (four-phase handshake)
//           RW       1 = read, 0 = write
//           SIZE     00 byte, 01 halfword, 10 word, 11 illegal
//           ADDR     byte address (from MAR)
//           DATA_IN  write data (from MDR)
//           DATA_OUT read data (to MDR)
//           MOC      memory operation complete
//           ERR      alignment/size error, qualified by MOC
// Modports: master = datapath side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_memory_responder_if;
   logic        MOV;
   logic        RW;
   logic [1:0]  SIZE;
   logic [7:0]  ADDR;
   logic [31:0] DATA_IN;
   logic [31:0] DATA_OUT;
   logic        MOC;
   logic        ERR;

   modport master (
      output MOV, RW, SIZE, ADDR, DATA_IN,
      input  DATA_OUT, MOC, ERR
   );

   modport slave (
      input  MOV, RW, SIZE, ADDR, DATA_IN,
      output DATA_OUT, MOC, ERR
   );
endinterface

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Purpose : 256 x 8-bit big-endian data memory with a MOV/MOC four-phase
//           handshake and WAIT_CYCLES wait states per access.
// Ports   : CLK       clock, rising edge
//           CLR       asynchronous active-low reset (storage is not cleared)
//           bus       data_memory_responder_if.slave (MOV, RW, SIZE, ADDR,
//                     DATA_IN in; DATA_OUT, MOC, ERR out, all registered)
//           state_dbg current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: the datapath raises MOV with a stable request; the request is
// captured on the first edge MOV is seen in IDLE. After WAIT_CYCLES+1 edges
// MOC rises (ERR alongside it for illegal accesses). MOC stays high until
// MOV = 0 is sampled, then MOC and ERR drop on that same edge and the block
// returns to IDLE. If MOV was already low when the access completed, MOC is a
// single-cycle pulse. A new request is accepted only from IDLE.
// -----------------------------------------------------------------------------
module data_memory_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                    CLK,
   input  logic                    CLR,
   data_memory_responder_if.slave  bus,
   output logic [1:0]              state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [3:0]  wait_cnt;
   logic        rw_q;
   logic [1:0]  size_q;
   logic [7:0]  addr_q;
   logic [31:0] wdata_q;

   logic [31:0] dout_q;
   logic        moc_q;
   logic        err_q;

   logic [31:0] dout_d;
   logic        moc_d;
   logic        err_d;

   // Storage is deliberately outside the reset domain; it starts at zero.
   logic [7:0]  mem [0:255] = '{default: 8'h00};

   logic        start;
   logic        access;
   logic        acc_err;
   logic        do_write;
   logic [7:0]  addr_p1;
   logic [7:0]  addr_p2;
   logic [7:0]  addr_p3;
   logic [31:0] rd_data;

   assign start   = (state == IDLE) && bus.MOV;
   assign access  = (state == BUSY) && (wait_cnt == 4'd0);

   assign addr_p1 = addr_q + 8'd1;
   assign addr_p2 = addr_q + 8'd2;
   assign addr_p3 = addr_q + 8'd3;

   // Misaligned halfword/word or the reserved size code.
   assign acc_err = (size_q == 2'b11) ||
                    ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

   // Gated by CLR so a reset landing on the access edge aborts the write.
   assign do_write = access && !rw_q && !acc_err && CLR;

   always_comb begin
      rd_data = 32'h0;
      case (size_q)
         2'b00:   rd_data = {24'h0, mem[addr_q]};
         2'b01:   rd_data = {16'h0, mem[addr_q], mem[addr_p1]};
         2'b10:   rd_data = {mem[addr_q], mem[addr_p1], mem[addr_p2], mem[addr_p3]};
         default: rd_data = 32'h0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register plus request latch and wait counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         rw_q     <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 8'h00;
         wdata_q  <= 32'h0;
      end else begin
         state <= next_state;
         if (start) begin
            wait_cnt <= 4'(WAIT_CYCLES);
            rw_q     <= bus.RW;
            size_q   <= bus.SIZE;
            addr_q   <= bus.ADDR;
            wdata_q  <= bus.DATA_IN;
         end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.MOV) next_state = BUSY;
         BUSY:    if (wait_cnt == 4'd0) next_state = DONE;
         DONE:    if (!bus.MOV) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: next values of the registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      dout_d = dout_q;
      moc_d  = 1'b0;
      err_d  = 1'b0;
      if (access) begin
         moc_d = 1'b1;
         err_d = acc_err;
         if (acc_err)
            dout_d = 32'h0;
         else if (rw_q)
            dout_d = rd_data;
      end else if ((state == DONE) && bus.MOV) begin
         moc_d = 1'b1;
         err_d = err_q;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         dout_q <= 32'h0;
         moc_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         moc_q  <= moc_d;
         err_q  <= err_d;
      end
   end

   // Big-endian store of the low 8/16/32 bits of the latched write data.
   always_ff @(posedge CLK) begin
      if (do_write) begin
         case (size_q)
            2'b00: mem[addr_q] <= wdata_q[7:0];
            2'b01: begin
               mem[addr_q]  <= wdata_q[15:8];
               mem[addr_p1] <= wdata_q[7:0];
            end
            2'b10: begin
               mem[addr_q]  <= wdata_q[31:24];
               mem[addr_p1] <= wdata_q[23:16];
               mem[addr_p2] <= wdata_q[15:8];
               mem[addr_p3] <= wdata_q[7:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.DATA_OUT = dout_q;
   assign bus.MOC      = moc_q;
   assign bus.ERR      = err_q;
   assign state_dbg    = state;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Purpose : Directed, table-driven check of data_memory_responder with three
//           instances (WAIT_CYCLES = 2, 0 and 3) sharing CLK and CLR.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int S_W2 = 0;
   localparam int S_W0 = 1;
   localparam int S_W3 = 2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic       CLK;
   logic       CLR;
   logic [1:0] st2, st0, st3;

   data_memory_responder_if bus2 ();
   data_memory_responder_if bus0 ();
   data_memory_responder_if bus3 ();

   data_memory_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
      .CLK(CLK), .CLR(CLR), .bus(bus2.slave), .state_dbg(st2));
   data_memory_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
      .CLK(CLK), .CLR(CLR), .bus(bus0.slave), .state_dbg(st0));
   data_memory_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
      .CLK(CLK), .CLR(CLR), .bus(bus3.slave), .state_dbg(st3));

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver / monitor helpers
   // ---------------------------------------------------------------------------
   task automatic drive(input int sel, input logic mov, input logic rw,
                        input logic [1:0] size, input logic [7:0] addr,
                        input logic [31:0] din);
      case (sel)
         S_W2: begin
            bus2.MOV = mov; bus2.RW = rw; bus2.SIZE = size; bus2.ADDR = addr; bus2.DATA_IN = din;
         end
         S_W0: begin
            bus0.MOV = mov; bus0.RW = rw; bus0.SIZE = size; bus0.ADDR = addr; bus0.DATA_IN = din;
         end
         default: begin
            bus3.MOV = mov; bus3.RW = rw; bus3.SIZE = size; bus3.ADDR = addr; bus3.DATA_IN = din;
         end
      endcase
   endtask

   task automatic set_mov(input int sel, input logic mov);
      case (sel)
         S_W2:    bus2.MOV = mov;
         S_W0:    bus0.MOV = mov;
         default: bus3.MOV = mov;
      endcase
   endtask

   function automatic void sample(input int sel, output logic moc, output logic err,
                                  output logic [31:0] dout, output logic [1:0] st);
      case (sel)
         S_W2:    begin moc = bus2.MOC; err = bus2.ERR; dout = bus2.DATA_OUT; st = st2; end
         S_W0:    begin moc = bus0.MOC; err = bus0.ERR; dout = bus0.DATA_OUT; st = st0; end
         default: begin moc = bus3.MOC; err = bus3.ERR; dout = bus3.DATA_OUT; st = st3; end
      endcase
   endfunction

   // Full four-phase access: raise MOV, measure edges until MOC, drop MOV,
   // confirm MOC/ERR fall on the next edge.
   task automatic access(input int sel, input logic rw, input logic [1:0] size,
                         input logic [7:0] addr, input logic [31:0] din,
                         input int exp_lat, input string name,
                         output logic [31:0] dout, output logic err);
      logic       moc;
      logic [1:0] st;
      int         lat;
      @(negedge CLK);
      drive(sel, 1'b1, rw, size, addr, din);
      @(posedge CLK);
      lat = 0;
      moc = 1'b0;
      while (!moc && lat < 40) begin
         @(posedge CLK);
         #1;
         lat++;
         sample(sel, moc, err, dout, st);
      end
      check({name, " latency"}, lat, exp_lat);
      @(negedge CLK);
      set_mov(sel, 1'b0);
      @(posedge CLK);
      #1;
      begin
         logic [31:0] d2;
         logic        e2;
         sample(sel, moc, e2, d2, st);
         check({name, " release MOC/ERR/state"}, {29'h0, moc, e2, st == ST_IDLE},
               {29'h0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        rw;
      logic [1:0]  size;
      logic [7:0]  addr;
      logic [31:0] din;
      logic [31:0] exp_dout;
      logic        exp_err;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   initial begin
      logic [31:0] dout;
      logic        err;
      logic        moc;
      logic [1:0]  st;
      logic        ok;

      //               rw    size   addr    din            exp_dout       err
      vecs[0]  = '{1'b0, 2'b10, 8'h04, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 2'b00, 8'h04, 32'h0,        32'h000000DE, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 8'h05, 32'h0,        32'h000000AD, 1'b0};
      vecs[3]  = '{1'b1, 2'b00, 8'h06, 32'h0,        32'h000000BE, 1'b0};
      vecs[4]  = '{1'b1, 2'b00, 8'h07, 32'h0,        32'h000000EF, 1'b0};
      vecs[5]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 8'h0A, 32'h1234A5C3, 32'hDEADBEEF, 1'b0};
      vecs[7]  = '{1'b1, 2'b01, 8'h0A, 32'h0,        32'h0000A5C3, 1'b0};
      vecs[8]  = '{1'b1, 2'b10, 8'h08, 32'h0,        32'h0000A5C3, 1'b0};
      vecs[9]  = '{1'b1, 2'b10, 8'h05, 32'h0,        32'h00000000, 1'b1};
      vecs[10] = '{1'b0, 2'b01, 8'h03, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[11] = '{1'b1, 2'b10, 8'h00, 32'h0,        32'h00000000, 1'b0};
      vecs[12] = '{1'b0, 2'b11, 8'h04, 32'h12345678, 32'h00000000, 1'b1};
      vecs[13] = '{1'b1, 2'b10, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[14] = '{1'b0, 2'b00, 8'h0B, 32'hFFFFFF77, 32'hDEADBEEF, 1'b0};
      vecs[15] = '{1'b1, 2'b01, 8'h0A, 32'h0,        32'h0000A577, 1'b0};
      vecs[16] = '{1'b1, 2'b00, 8'hFF, 32'h0,        32'h00000000, 1'b0};
      vecs[17] = '{1'b0, 2'b10, 8'hFC, 32'hCAFEF00D, 32'h00000000, 1'b0};
      vecs[18] = '{1'b1, 2'b10, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0};
      vecs[19] = '{1'b1, 2'b01, 8'hFE, 32'h0,        32'h0000F00D, 1'b0};
      vecs[20] = '{1'b1, 2'b01, 8'h05, 32'h0,        32'h00000000, 1'b1};
      vecs[21] = '{1'b1, 2'b00, 8'h03, 32'h0,        32'h00000000, 1'b0};

      // ------------------------------------------------------------------------
      // Reset
      // ------------------------------------------------------------------------
      CLR = 1'b0;
      drive(S_W2, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      drive(S_W0, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      drive(S_W3, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      sample(S_W2, moc, err, dout, st);
      check("reset DATA_OUT", dout, 32'h0);
      check("reset MOC/ERR/state", {28'h0, moc, err, st}, {28'h0, 1'b0, 1'b0, ST_IDLE});
      @(negedge CLK);
      CLR = 1'b1;

      // ------------------------------------------------------------------------
      // Table-driven accesses, WAIT_CYCLES = 2 (latency 3)
      // ------------------------------------------------------------------------
      for (int i = 0; i < NV; i++) begin
         exp_q.push_back(vecs[i].exp_dout);
         access(S_W2, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].din, 3,
                $sformatf("vec%0d", i), dout, err);
         check($sformatf("vec%0d DATA_OUT", i), dout, exp_q.pop_front());
         check($sformatf("vec%0d ERR", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      end

      // ------------------------------------------------------------------------
      // MOV held high past MOC: MOC holds, no repeat, then full-latency restart
      // ------------------------------------------------------------------------
      @(negedge CLK);
      drive(S_W2, 1'b1, 1'b0, 2'b00, 8'h20, 32'h0000005A);
      @(posedge CLK);
      moc = 1'b0;
      for (int n = 0; n < 40 && !moc; n++) begin
         @(posedge CLK);
         #1;
         sample(S_W2, moc, err, dout, st);
      end
      check("hold: MOC reached", {31'h0, moc}, 32'h1);
      ok = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge CLK);
         #1;
         sample(S_W2, moc, err, dout, st);
         if (!(moc && !err && st == ST_DONE)) ok = 1'b0;
      end
      check("hold: MOC/DONE stable 5 cycles", {31'h0, ok}, 32'h1);
      @(negedge CLK);
      set_mov(S_W2, 1'b0);
      @(posedge CLK);
      #1;
      sample(S_W2, moc, err, dout, st);
      check("hold: MOC drops after MOV=0", {30'h0, moc, st == ST_IDLE}, {30'h0, 1'b0, 1'b1});
      access(S_W2, 1'b1, 2'b00, 8'h20, 32'h0, 3, "hold re-access", dout, err);
      check("hold re-access DATA_OUT", dout, 32'h0000005A);

      // ------------------------------------------------------------------------
      // Reset during a write in BUSY aborts it
      // ------------------------------------------------------------------------
      access(S_W2, 1'b0, 2'b10, 8'h10, 32'h11223344, 3, "pre-abort write", dout, err);
      @(negedge CLK);
      drive(S_W2, 1'b1, 1'b0, 2'b10, 8'h10, 32'hFFFFFFFF);
      @(posedge CLK);
      #1;
      check("abort: in BUSY", {30'h0, st2}, {30'h0, ST_BUSY});
      #2;
      CLR = 1'b0;
      #1;
      sample(S_W2, moc, err, dout, st);
      check("abort: DATA_OUT cleared", dout, 32'h0);
      check("abort: MOC/ERR/state cleared", {28'h0, moc, err, st}, {28'h0, 1'b0, 1'b0, ST_IDLE});
      set_mov(S_W2, 1'b0);
      @(negedge CLK);
      CLR = 1'b1;
      access(S_W2, 1'b1, 2'b10, 8'h10, 32'h0, 3, "abort readback", dout, err);
      check("abort readback DATA_OUT", dout, 32'h11223344);

      // ------------------------------------------------------------------------
      // WAIT_CYCLES = 0: MOC after one edge
      // ------------------------------------------------------------------------
      access(S_W0, 1'b0, 2'b10, 8'h00, 32'hA1B2C3D4, 1, "w0 write", dout, err);
      access(S_W0, 1'b1, 2'b01, 8'h02, 32'h0, 1, "w0 read", dout, err);
      check("w0 read DATA_OUT", dout, 32'h0000C3D4);

      // ------------------------------------------------------------------------
      // WAIT_CYCLES = 3 with MOV dropped during BUSY: single-cycle MOC
      // ------------------------------------------------------------------------
      @(negedge CLK);
      drive(S_W3, 1'b1, 1'b1, 2'b00, 8'h00, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      set_mov(S_W3, 1'b0);
      for (int e = 1; e <= 6; e++) begin
         @(posedge CLK);
         #1;
         sample(S_W3, moc, err, dout, st);
         check($sformatf("w3 drop edge%0d MOC", e), {31'h0, moc}, {31'h0, e == 4});
         if (e == 5) check("w3 drop back to IDLE", {30'h0, st}, {30'h0, ST_IDLE});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
